// File: rtl/uart_reg_master.sv
// Host-side initiator for the UART register file: programs BAUD/ENABLE, paces TX_DATA writes, serves RX_DATA reads.
// Optional TX frame counter output tx_count is built when UART_REG_MASTER_TXCNT_EN is defined.
module uart_reg_master #(
    parameter int unsigned FRAME_BITS = 10,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  cfg_baud,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic        rd_req,
    output logic [7:0]  rd_data,
    output logic        rd_done,
    output logic        configured,
    output logic [1:0]  address,
    output logic [7:0]  write_data,
    output logic        we,
    output logic        re,
    input  logic [7:0]  read_data
`ifdef UART_REG_MASTER_TXCNT_EN
  , output logic [15:0] tx_count
`endif
);

    localparam logic [1:0] ADDR_BAUD   = 2'd0;
    localparam logic [1:0] ADDR_ENABLE = 2'd1;
    localparam logic [1:0] ADDR_TX     = 2'd2;
    localparam logic [1:0] ADDR_RX     = 2'd3;
    localparam logic [1:0] LAT_LOAD    = 2'(RD_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE,
        CFG_BAUD,
        CFG_EN,
        READY,
        TX_WR,
        TX_WAIT,
        RD_ISSUE,
        RD_CAPTURE
    } state_t;

    state_t      state_q;
    logic [1:0]  address_q;
    logic [7:0]  write_data_q;
    logic        we_q;
    logic        re_q;
    logic [7:0]  rd_data_q;
    logic        rd_done_q;
    logic        configured_q;
    logic [7:0]  baud_q;
    logic [15:0] frame_cnt_q;
    logic [1:0]  lat_cnt_q;
    logic [15:0] frame_load_d;

    // Frame time minus one: the wait counter runs F-1 down to 0, giving exactly F wait cycles.
    assign frame_load_d = 16'(({8'd0, baud_q} + 16'd1) * 16'(FRAME_BITS)) - 16'd1;

    assign cfg_ready  = (state_q == IDLE) || (state_q == READY);
    assign s_ready    = (state_q == READY) && configured_q && !cfg_valid && !rd_req;
    assign address    = address_q;
    assign write_data = write_data_q;
    assign we         = we_q;
    assign re         = re_q;
    assign rd_data    = rd_data_q;
    assign rd_done    = rd_done_q;
    assign configured = configured_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            address_q    <= ADDR_BAUD;
            write_data_q <= 8'h00;
            we_q         <= 1'b0;
            re_q         <= 1'b0;
            rd_data_q    <= 8'h00;
            rd_done_q    <= 1'b0;
            configured_q <= 1'b0;
            baud_q       <= 8'h00;
            frame_cnt_q  <= 16'h0000;
            lat_cnt_q    <= 2'd0;
        end else begin
            we_q      <= 1'b0;
            re_q      <= 1'b0;
            rd_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cfg_valid) begin
                        state_q      <= CFG_BAUD;
                        address_q    <= ADDR_BAUD;
                        write_data_q <= cfg_baud;
                        baud_q       <= cfg_baud;
                        we_q         <= 1'b1;
                    end
                end
                CFG_BAUD: begin
                    state_q      <= CFG_EN;
                    address_q    <= ADDR_ENABLE;
                    write_data_q <= 8'h01;
                    we_q         <= 1'b1;
                end
                CFG_EN: begin
                    state_q      <= READY;
                    configured_q <= 1'b1;
                end
                READY: begin
                    // Reconfiguration wins over reads, reads win over TX bytes.
                    if (cfg_valid) begin
                        state_q      <= CFG_BAUD;
                        address_q    <= ADDR_BAUD;
                        write_data_q <= cfg_baud;
                        baud_q       <= cfg_baud;
                        we_q         <= 1'b1;
                    end else if (rd_req) begin
                        state_q   <= RD_ISSUE;
                        address_q <= ADDR_RX;
                        re_q      <= 1'b1;
                        lat_cnt_q <= LAT_LOAD;
                    end else if (s_valid && configured_q) begin
                        state_q      <= TX_WR;
                        address_q    <= ADDR_TX;
                        write_data_q <= s_data;
                        we_q         <= 1'b1;
                    end
                end
                TX_WR: begin
                    state_q     <= TX_WAIT;
                    frame_cnt_q <= frame_load_d;
                end
                TX_WAIT: begin
                    if (frame_cnt_q == 16'd0) begin
                        state_q <= READY;
                    end else begin
                        frame_cnt_q <= frame_cnt_q - 16'd1;
                    end
                end
                RD_ISSUE: begin
                    if (lat_cnt_q == 2'd0) begin
                        state_q   <= RD_CAPTURE;
                        rd_data_q <= read_data;
                        rd_done_q <= 1'b1;
                    end else begin
                        lat_cnt_q <= lat_cnt_q - 2'd1;
                    end
                end
                RD_CAPTURE: begin
                    state_q <= READY;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef UART_REG_MASTER_TXCNT_EN
    logic [15:0] tx_count_q;

    // Counts completed frames; survives reconfiguration, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_count_q <= 16'h0000;
        end else if (state_q == TX_WAIT && frame_cnt_q == 16'd0) begin
            tx_count_q <= tx_count_q + 16'd1;
        end
    end

    assign tx_count = tx_count_q;
`endif

endmodule

// File: tb/tb_uart_reg_master.sv
// Scoreboard bench for uart_reg_master: stimulus pushes expected bus events, a negedge monitor pops and compares.
module tb_uart_reg_master;

    localparam int FB  = 10;
    localparam int RDL = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] cfg_baud;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic       rd_req;
    logic [7:0] rd_data;
    logic       rd_done;
    logic       configured;
    logic [1:0] address;
    logic [7:0] write_data;
    logic       we;
    logic       re;
    logic [7:0] read_data;
`ifdef UART_REG_MASTER_TXCNT_EN
    logic [15:0] tx_count;
`endif

    always #5 clk = ~clk;

    uart_reg_master #(.FRAME_BITS(FB), .RD_LATENCY(RDL)) dut (
        .clk(clk), .rst(rst),
        .cfg_baud(cfg_baud), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .rd_req(rd_req), .rd_data(rd_data), .rd_done(rd_done),
        .configured(configured),
        .address(address), .write_data(write_data), .we(we), .re(re),
        .read_data(read_data)
`ifdef UART_REG_MASTER_TXCNT_EN
      , .tx_count(tx_count)
`endif
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // kind: 0 = register write, 1 = read strobe, 2 = rd_done
    typedef struct {
        string      name;
        int         kind;
        logic [1:0] addr;
        logic [7:0] data;
        int         at;
    } exp_t;

    exp_t exp_q[$];

    task automatic push_exp(input string nm, input int kind, input logic [1:0] a,
                            input logic [7:0] d, input int at);
        exp_t e;
        e.name = nm; e.kind = kind; e.addr = a; e.data = d; e.at = at;
        exp_q.push_back(e);
    endtask

    task automatic check_event(input int kind, input logic [1:0] a, input logic [7:0] d);
        exp_t e;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got kind=%0d addr=%0d data=%02h cyc=%0d, required no event",
                     kind, a, d, cyc);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != kind || e.at != cyc || (kind != 1 && e.data != d) || (kind != 2 && e.addr != a)) begin
            n_fail++;
            $display("FAIL %s: got kind=%0d addr=%0d data=%02h cyc=%0d, required kind=%0d addr=%0d data=%02h cyc=%0d",
                     e.name, kind, a, d, cyc, e.kind, e.addr, e.data, e.at);
        end else begin
            $display("[TB] cyc=%0d %s kind=%0d addr=%0d data=%02h ok", cyc, e.name, kind, a, d);
        end
    endtask

    // Monitor: every strobe or rd_done must match the head of the scoreboard.
    always @(negedge clk) begin
        if (cyc >= 1) begin
            if (we === 1'b1 && re === 1'b1) begin
                n_tests++;
                n_fail++;
                $display("FAIL we_re_overlap: got we=1 re=1 cyc=%0d, required at most one", cyc);
            end
            if (we === 1'b1) check_event(0, address, write_data);
            else if (re === 1'b1) check_event(1, address, 8'h00);
            if (rd_done === 1'b1) check_event(2, 2'd3, rd_data);
        end
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (cyc=%0d)", nm, act, req, cyc);
        end
    endtask

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic timeout(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got timeout required handshake (cyc=%0d)", nm, cyc);
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 300; i++) begin
            if (cfg_ready === 1'b1 && configured === 1'b1) return;
            step(1);
        end
        timeout("wait_ready");
    endtask

    task automatic do_cfg(input logic [7:0] b);
        int n;
        bit ok;
        ok = 0;
        cfg_baud  = b;
        cfg_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (cfg_ready === 1'b1) begin ok = 1; break; end
            step(1);
        end
        if (!ok) begin cfg_valid = 1'b0; timeout("cfg_handshake"); return; end
        n = cyc;
        push_exp("cfg_baud_wr", 0, 2'd0, b, n + 1);
        push_exp("cfg_en_wr", 0, 2'd1, 8'h01, n + 2);
        step(1);
        cfg_valid = 1'b0;
        step(2);
        chk("configured_after_cfg", 16'(configured), 16'd1);
        chk("cfg_ready_after_cfg", 16'(cfg_ready), 16'd1);
    endtask

    task automatic send_byte(input logic [7:0] d, output int acc);
        bit ok;
        ok  = 0;
        acc = -1;
        s_data  = d;
        s_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (s_ready === 1'b1) begin ok = 1; break; end
            step(1);
        end
        if (!ok) begin s_valid = 1'b0; timeout("tx_handshake"); return; end
        acc = cyc;
        push_exp("tx_wr", 0, 2'd2, d, acc + 1);
        step(1);
        s_valid = 1'b0;
    endtask

    task automatic do_read(input logic [7:0] v);
        int n;
        bit ok;
        ok = 0;
        read_data = v;
        rd_req    = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (cfg_ready === 1'b1 && configured === 1'b1 && cfg_valid == 1'b0) begin ok = 1; break; end
            step(1);
        end
        if (!ok) begin rd_req = 1'b0; timeout("rd_handshake"); return; end
        n = cyc;
        push_exp("rd_issue", 1, 2'd3, 8'h00, n + 1);
        push_exp("rd_done", 2, 2'd3, v, n + 1 + RDL);
        step(1);
        rd_req = 1'b0;
        step(RDL + 1);
        chk("ready_after_read", 16'(cfg_ready), 16'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, a1, n, acc;
        rst = 1'b0; cfg_baud = 8'h00; cfg_valid = 1'b0; s_data = 8'h00;
        s_valid = 1'b0; rd_req = 1'b0; read_data = 8'h00;

        // Reset held with toggling inputs
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("rst_we", 16'(we), 16'd0);
            chk("rst_re", 16'(re), 16'd0);
            chk("rst_address", 16'(address), 16'd0);
            chk("rst_write_data", 16'(write_data), 16'd0);
            chk("rst_configured", 16'(configured), 16'd0);
            chk("rst_cfg_ready", 16'(cfg_ready), 16'd1);
            chk("rst_s_ready", 16'(s_ready), 16'd0);
            cfg_valid = ~cfg_valid; s_valid = ~s_valid; rd_req = ~rd_req;
            cfg_baud = 8'(i * 37); s_data = 8'(i * 91); read_data = 8'(i * 13);
        end
        cfg_valid = 1'b0; s_valid = 1'b0; rd_req = 1'b0; read_data = 8'h00;
        rst = 1'b1;

        // Configuration and TX pacing with baud 3: F = 40
        do_cfg(8'h03);
        send_byte(8'hA5, a0);
        send_byte(8'h5A, a1);
        chk("tx_accept_spacing", 16'(a1 - a0), 16'(4 * FB + 2));

        // Read is held off until the second frame finishes
        do_read(8'h3C);

        // rd_req held: a second read follows right after rd_done
        read_data = 8'h7E;
        rd_req    = 1'b1;
        n = cyc;
        push_exp("rd_issue_b2b0", 1, 2'd3, 8'h00, n + 1);
        push_exp("rd_done_b2b0", 2, 2'd3, 8'h7E, n + 1 + RDL);
        push_exp("rd_issue_b2b1", 1, 2'd3, 8'h00, n + 3 + RDL);
        push_exp("rd_done_b2b1", 2, 2'd3, 8'h7E, n + 3 + 2 * RDL);
        step(3 + RDL);
        rd_req = 1'b0;
        step(RDL + 1);
        chk("ready_after_b2b", 16'(cfg_ready), 16'd1);

        // Priority: cfg > rd > tx, all raised together in READY; baud 0 gives F = FRAME_BITS
        n = cyc;
        cfg_baud = 8'h00; cfg_valid = 1'b1; rd_req = 1'b1;
        s_valid = 1'b1; s_data = 8'hC3; read_data = 8'h96;
        push_exp("prio_baud_wr", 0, 2'd0, 8'h00, n + 1);
        push_exp("prio_en_wr", 0, 2'd1, 8'h01, n + 2);
        push_exp("prio_rd_issue", 1, 2'd3, 8'h00, n + 4);
        push_exp("prio_rd_done", 2, 2'd3, 8'h96, n + 4 + RDL);
        push_exp("prio_tx_wr", 0, 2'd2, 8'hC3, n + 6 + RDL);
        step(1);
        cfg_valid = 1'b0;
        chk("prio_s_ready_in_cfg", 16'(s_ready), 16'd0);
        chk("prio_configured_kept", 16'(configured), 16'd1);
        step(3);
        rd_req = 1'b0;
        step(2 + RDL);
        s_valid = 1'b0;
        acc = n + 5 + RDL;
        send_byte(8'h3D, a1);
        chk("baud0_accept_spacing", 16'(a1 - acc), 16'(FB + 2));

        // Reset 10 cycles into a TX wait with baud 5 (F = 60)
        do_cfg(8'h05);
        send_byte(8'h11, a0);
        step(11);
        rst = 1'b0;
        step(1);
        chk("mid_rst_we", 16'(we), 16'd0);
        chk("mid_rst_re", 16'(re), 16'd0);
        chk("mid_rst_address", 16'(address), 16'd0);
        chk("mid_rst_write_data", 16'(write_data), 16'd0);
        chk("mid_rst_rd_data", 16'(rd_data), 16'd0);
        chk("mid_rst_rd_done", 16'(rd_done), 16'd0);
        chk("mid_rst_configured", 16'(configured), 16'd0);
        rst = 1'b1;
        s_data = 8'hEE; s_valid = 1'b1;
        step(80);
        chk("unconfigured_s_ready", 16'(s_ready), 16'd0);
        chk("unconfigured_flag", 16'(configured), 16'd0);
        s_valid = 1'b0;
        do_cfg(8'h02);
        send_byte(8'hEE, a0);
        wait_ready();
`ifdef UART_REG_MASTER_TXCNT_EN
        chk("tx_count", tx_count, 16'd1);
`endif
        step(5);
        chk("scoreboard_drained", 16'(exp_q.size()), 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
